fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, address width of PC and memory address.
REQ-002 Parameter DEPTH, default 4, instruction buffer entries and max outstanding requests; power of two, >=2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts request.
REQ-008 imem_req_addr  out  ADDR_W  fetch address, bits [1:0] always 00.
REQ-009 imem_rsp_valid  in  1  response valid, in request order, always accepted.
REQ-010 imem_rsp_data  in  32  instruction word.
REQ-011 redirect_valid  in  1  branch/jump redirect, single-cycle pulse.
REQ-012 redirect_target  in  ADDR_W  redirect address.
REQ-013 instr_valid  out  1  buffer head valid.
REQ-014 instr_ready  in  1  consumer accepts head.
REQ-015 instr_data  out  32  head instruction word.
REQ-016 instr_pc  out  ADDR_W  PC of head instruction.
REQ-017 trap_valid  out  1  misaligned-target trap pending.
REQ-018 trap_addr  out  ADDR_W  offending target.

Function
REQ-019 Internal state: fetch_pc, rsp_pc, FIFO of DEPTH {data,pc}, outstanding counter, drop counter, trap flag.
REQ-020 imem_req_valid SHALL be 1 iff outstanding + FIFO count < DEPTH, trap flag clear and redirect_valid=0; imem_req_addr = fetch_pc.
REQ-021 On request handshake fetch_pc SHALL advance by 4, modulo 2^ADDR_W (wrap to 0), and outstanding SHALL increment.
REQ-022 Once asserted, imem_req_valid/addr SHALL hold until handshake, except withdrawal in a redirect cycle.
REQ-023 On imem_rsp_valid outstanding SHALL decrement; if drop counter > 0, response discarded and drop counter decremented; else {data, rsp_pc} pushed and rsp_pc += 4.
REQ-024 Pushed entry visible on instr_* the next cycle (min latency request-accept to instr_valid: memory latency + 1); no combinational path imem_rsp_* to instr_*.
REQ-025 Pop on instr_valid & instr_ready; simultaneous push and pop at full or empty SHALL be correct; FIFO never overflows by credit rule.
REQ-026 redirect_valid has priority over every same-cycle event: FIFO cleared (instr_valid=0 next cycle), pop ignored, fetch_pc and rsp_pc <= aligned target, drop counter <= outstanding minus same-cycle response.
REQ-027 Back-to-back redirects SHALL accumulate drop count correctly; last redirect wins.
REQ-028 Responses arriving with outstanding=0 are a protocol error; behaviour undefined.

Reset
REQ-029 While rst=1: all outputs 0 except imem_req_addr=RESET_PC; FIFO empty; counters 0; trap clear; fetch_pc=rsp_pc=RESET_PC.
REQ-030 First request asserted in first cycle with rst=0.
REQ-031 Reset mid-operation discards all in-flight state; memory SHALL be reset in the same cycle.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN.
REQ-033 Defined: redirect with target[1]=1 flushes as REQ-026, sets trap flag, trap_valid=1, trap_addr=target, requests stop; cleared by next redirect with target[1]=0 or reset.
REQ-034 Not defined: target[1:0] forced to 00; trap_valid and trap_addr tied 0.
REQ-035 target[0] always ignored (cleared).

Verification
REQ-036 Reset, 1-cycle memory, instr_ready=1 -> instr_pc 0x0,0x4,0x8... one per cycle, data matches memory.
REQ-037 instr_ready=0, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0 until a pop.
REQ-038 3-cycle memory, 3 outstanding, redirect to 0x100 -> 3 responses dropped, next instr_pc=0x100 with correct data.
REQ-039 Redirect to 0xFFFFFFFC -> instr_pc 0xFFFFFFFC then 0x00000000.
REQ-040 Macro defined, redirect to 0x102 -> trap_valid=1, trap_addr=0x102, no requests; redirect to 0x200 clears trap, fetch resumes at 0x200; macro undefined, 0x102 -> fetch at 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// In-order instruction fetch: credit-limited request issue, DEPTH-entry instruction
// buffer, redirect flush with drop counting. Optional macro FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              trap_valid,
    output logic [ADDR_W-1:0] trap_addr
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_L = DEPTH[CNT_W:0];
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic [CNT_W:0]    inflight;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic              trap_q;
    logic [ADDR_W-1:0] tgt_aligned;
    logic              unused_tgt;

    // Bit 0 is never meaningful; bit 1 either traps or is dropped.
    assign tgt_aligned = {redirect_target[ADDR_W-1:2], 2'b00};
    assign unused_tgt  = ^redirect_target[1:0];

    // Every in-flight request owns a buffer slot, so the buffer can never overflow.
    assign inflight       = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !rst && (inflight < DEPTH_L) && !trap_q && !redirect_valid;
    assign imem_req_addr  = rst ? RESET_PC : fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = (count != '0);
    assign instr_data  = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the old path and must be discarded.
            fetch_pc    <= tgt_aligned;
            rsp_pc      <= tgt_aligned;
            outstanding <= outstanding - CNT_W'(imem_rsp_valid);
            drop_cnt    <= outstanding - CNT_W'(imem_rsp_valid);
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (push) begin
                rsp_pc <= rsp_pc + PC_STEP;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (req_fire && !imem_rsp_valid) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (!req_fire && imem_rsp_valid) begin
                outstanding <= outstanding - CNT_W'(1);
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic [ADDR_W-1:0] trap_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else if (redirect_valid) begin
            trap_q <= redirect_target[1];
        end
    end

    always_ff @(posedge clk) begin
        if (redirect_valid && redirect_target[1]) begin
            trap_addr_q <= {redirect_target[ADDR_W-1:1], 1'b0};
        end
    end

    assign trap_valid = trap_q;
    assign trap_addr  = trap_q ? trap_addr_q : '0;
`else
    assign trap_q     = 1'b0;
    assign trap_valid = 1'b0;
    assign trap_addr  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory responder with programmable latency,
// expected-instruction queue checked on every consumed buffer entry.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        trap_valid;
    logic [31:0] trap_addr;

    fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .trap_valid      (trap_valid),
        .trap_addr       (trap_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    // Memory responder: in-order, fixed latency, reset together with the DUT.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    mcyc  = 0;
    int    n_req = 0;
    int    lat   = 1;

    always @(posedge clk) begin
        mreq_t m;
        mcyc <= mcyc + 1;
        if (rst) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{addr: imem_req_addr, due: mcyc + lat});
                n_req <= n_req + 1;
            end
            if (mq.size() != 0 && mq[0].due <= mcyc + 1) begin
                m = mq.pop_front();
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_word(m.addr);
            end else begin
                imem_rsp_valid <= 1'b0;
                imem_rsp_data  <= '0;
            end
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   tcyc      = 0;
    int   first_pop = -1;
    int   last_pop  = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        if (instr_valid === 1'b1 && instr_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_pop: got pc %h, expected no instruction", instr_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr_data", instr_data, e.data);
            end
            if (first_pop < 0) first_pop = tcyc;
            last_pop = tcyc;
        end
    endtask

    // One clock: sample the pending consumption, then advance to the next falling edge.
    task automatic tick();
        #1;
        sb_check();
        @(negedge clk);
        tcyc++;
    endtask

    task automatic expect_run(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: pc, data: mem_word(pc)});
            pc = pc + 32'd4;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_bad++;
            $error("FAIL %s_timeout: got %0d pending, expected 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Three requests in flight on a 3-cycle memory, then one or two redirects.
    task automatic flush_test(input logic [31:0] t1, input bit two, input logic [31:0] t2);
        do_reset(2);
        lat = 3;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = t1;
        #1;
        check("req_withdrawn_on_redirect", {31'd0, imem_req_valid}, 32'd0);
        tick();
        if (two) begin
            redirect_target = t2;
            tick();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        expect_run(two ? t2 : t1, 6);
        drain("flush", 60);
        instr_ready = 1'b0;
    endtask

    int base;

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = '0;
        instr_ready = 1'b0;

        // Reset state
        do_reset(3);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr_data", instr_data, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_trap_valid", {31'd0, trap_valid}, 32'd0);
        check("rst_trap_addr", trap_addr, 32'h0);

        // Streaming with a 1-cycle memory and an always-ready consumer
        lat = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        first_pop = -1;
        expect_run(32'h0, 12);
        drain("stream", 100);
        check("stream_one_per_cycle", last_pop - first_pop, 32'd11);
        instr_ready = 1'b0;

        // Stalled consumer: credits cap requests at DEPTH; reset lands mid-stream
        do_reset(2);
        check("midrst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        base = n_req;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("stall_req_count", n_req - base, 32'd4);
        check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
        expect_run(32'h0, 1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        check("after_pop_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("after_pop_req_addr", imem_req_addr, 32'h10);
        check("after_pop_drained", exp_q.size(), 32'd0);
        exp_q.delete();

        // Redirect with three requests in flight, then back-to-back redirects
        flush_test(32'h100, 1'b0, 32'h0);
        flush_test(32'h200, 1'b1, 32'h300);

        // Redirect near the top of the address space wraps to zero
        do_reset(2);
        lat = 1;
        imem_req_ready = 1'b0;
        instr_ready = 1'b1;
        rst = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        expect_run(32'hFFFF_FFFC, 4);
        drain("wrap", 40);
        instr_ready = 1'b0;

        // Misaligned redirect target
        do_reset(2);
        lat = 1;
        imem_req_ready = 1'b0;
        instr_ready = 1'b1;
        rst = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'h102;
        tick();
        redirect_valid = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_valid_set", {31'd0, trap_valid}, 32'd1);
        check("trap_addr", trap_addr, 32'h102);
        check("trap_req_valid", {31'd0, imem_req_valid}, 32'd0);
        imem_req_ready = 1'b1;
        base = n_req;
        for (int i = 0; i < 6; i++) tick();
        check("trap_no_requests", n_req - base, 32'd0);
        check("trap_instr_valid", {31'd0, instr_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_target = 32'h201;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("trap_cleared", {31'd0, trap_valid}, 32'd0);
        check("trap_resume_addr", imem_req_addr, 32'h200);
        expect_run(32'h200, 3);
        drain("trap_resume", 40);
`else
        check("notrap_trap_valid", {31'd0, trap_valid}, 32'd0);
        check("notrap_trap_addr", trap_addr, 32'h0);
        check("notrap_req_addr", imem_req_addr, 32'h100);
        imem_req_ready = 1'b1;
        expect_run(32'h100, 3);
        drain("notrap", 40);
`endif
        instr_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
